// File: rtl/tinyqv_fetch_pkg.sv
// tinyqv_fetch_pkg
// Shared types and constants for the instruction prefetch buffer.
//   fetch_state_e : prefetch FSM states (FETCH, STREAM, WAIT)
//   halfword_t    : one 16-bit instruction parcel
//   LEN32_CODE    : low two bits that mark a 32-bit instruction
//   LEN_16/LEN_32 : instruction length encodings, in halfwords
//   decode_len()  : instruction length taken from its first halfword
package tinyqv_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } fetch_state_e;

    typedef logic [15:0] halfword_t;

    localparam logic [1:0] LEN32_CODE = 2'b11;
    localparam logic [1:0] LEN_16     = 2'b01;
    localparam logic [1:0] LEN_32     = 2'b10;

    // Any first halfword whose low bits are not 2'b11 is a compressed instruction.
    function automatic logic [1:0] decode_len(input halfword_t hw);
        logic [1:0] len;
        if (hw[1:0] == LEN32_CODE) begin
            len = LEN_32;
        end else begin
            len = LEN_16;
        end
        return len;
    endfunction

endpackage

// File: rtl/tinyqv_fetch_buffer_checker.sv
// tinyqv_fetch_buffer_checker
// Simulation-only protocol checks for tinyqv_fetch_buffer.
// Ports: clk, rst, instr_complete, instr_valid, fetch_stop (all observed only).
module tinyqv_fetch_buffer_checker (
    input logic clk,
    input logic rst,
    input logic instr_complete,
    input logic instr_valid,
    input logic fetch_stop
);

    // The consumer may only pop an instruction that is being presented.
    a_pop_needs_valid: assert property (
        @(posedge clk) disable iff (rst) instr_complete |-> instr_valid
    );

    // fetch_stop is a single-cycle pulse.
    a_stop_is_pulse: assert property (
        @(posedge clk) disable iff (rst) fetch_stop |=> !fetch_stop
    );

endmodule

// File: rtl/tinyqv_hw_ring.sv
// tinyqv_hw_ring
// DEPTH_HW x 16-bit halfword ring storage for the prefetch buffer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push              : write wr_data into slot wr_ptr
//   wr_ptr, wr_data   : write slot and halfword
//   rd_ptr            : read slot of the oldest buffered halfword
//   rd_lo, rd_hi      : hw[rd_ptr] and hw[rd_ptr+1] (index wraps)
module tinyqv_hw_ring
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH_HW = 4,
    parameter int PTR_W    = $clog2(DEPTH_HW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [PTR_W-1:0] wr_ptr,
    input  halfword_t        wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output halfword_t        rd_lo,
    output halfword_t        rd_hi
);

    halfword_t        mem_r [DEPTH_HW];
    logic [PTR_W-1:0] rd_next_s;

    // Second read slot wraps naturally because the pointer is PTR_W bits wide.
    assign rd_next_s = rd_ptr + PTR_W'(1'b1);
    assign rd_lo     = mem_r[rd_ptr];
    assign rd_hi     = mem_r[rd_next_s];

    // Halfword storage write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_HW; i++) begin
                mem_r[i] <= 16'h0000;
            end
        end else if (push) begin
            mem_r[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/tinyqv_fetch_buffer.sv
// tinyqv_fetch_buffer
// Instruction prefetch stage: streams halfwords from the memory controller
// into a small ring and presents a halfword-aligned 32-bit instruction word.
// Configuration macro: TINYQV_FETCH_RVC_EN enables 16-bit (RVC) instructions;
// without it every instruction is 32 bits and branch targets are word aligned.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   fetch_req/_addr   : ask memory to stream from fetch_addr
//   fetch_started     : memory accepted fetch_req
//   data_in/_valid    : streamed halfword (never on consecutive cycles)
//   fetch_stop        : one-cycle pulse ending the current stream
//   instr, pc, instr_len, instr_valid : presented instruction
//   instr_complete    : pop the presented instruction
//   branch/_addr      : flush and redirect fetch
module tinyqv_fetch_buffer
    import tinyqv_fetch_pkg::*;
#(
    parameter int                     DEPTH_HW   = 4,
    parameter int                     ADDR_W     = 24,
    parameter logic [ADDR_W-1:0]      RESET_ADDR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_started,
    input  logic [15:0]       data_in,
    input  logic              data_valid,
    output logic              fetch_stop,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        instr_len,
    output logic              instr_valid,
    input  logic              instr_complete,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_addr
);

    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = $clog2(DEPTH_HW) + 1;

`ifdef TINYQV_FETCH_RVC_EN
    localparam logic [ADDR_W-1:0] BR_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};
`else
    localparam logic [ADDR_W-1:0] BR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

    fetch_state_e      state_r;
    logic              fetch_req_r;
    logic              fetch_stop_r;
    logic [ADDR_W-1:0] fetch_addr_r;
    logic [ADDR_W-1:0] pc_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  rd_r;
    logic [PTR_W-1:0]  wr_r;

    halfword_t         hw_lo_s;
    halfword_t         hw_hi_s;
    logic [1:0]        len_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  next_count_s;
    logic [ADDR_W-1:0] branch_target_s;
    logic [ADDR_W-1:0] resume_addr_s;

    tinyqv_hw_ring #(
        .DEPTH_HW (DEPTH_HW),
        .PTR_W    (PTR_W)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_ptr  (wr_r),
        .wr_data (data_in),
        .rd_ptr  (rd_r),
        .rd_lo   (hw_lo_s),
        .rd_hi   (hw_hi_s)
    );

    tinyqv_fetch_buffer_checker u_checker (
        .clk            (clk),
        .rst            (rst),
        .instr_complete (instr_complete),
        .instr_valid    (instr_valid),
        .fetch_stop     (fetch_stop)
    );

    // Instruction length and presentation validity from the oldest halfword.
    always_comb begin
        len_s   = LEN_32;
        valid_s = 1'b0;
`ifdef TINYQV_FETCH_RVC_EN
        len_s = decode_len(hw_lo_s);
        if (count_r >= CNT_W'(2'd2)) begin
            valid_s = 1'b1;
        end else if ((count_r == CNT_W'(1'b1)) && (len_s == LEN_16)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
`else
        if (count_r >= CNT_W'(2'd2)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
`endif
    end

    // Push/pop qualification; branch discards both the data and the pop.
    always_comb begin
        push_s       = data_valid && (state_r == STREAM) && !branch;
        pop_s        = instr_complete && valid_s && !branch;
        next_count_s = count_r + CNT_W'(push_s);
        if (pop_s) begin
            next_count_s = count_r + CNT_W'(push_s) - CNT_W'(len_s);
        end else begin
            next_count_s = count_r + CNT_W'(push_s);
        end
        branch_target_s = branch_addr & BR_MASK;
        // Address just past the last buffered halfword; invariant under pops.
        resume_addr_s   = pc_r + ADDR_W'({count_r, 1'b0});
    end

    // Fetch FSM, occupancy, ring pointers and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= FETCH;
            fetch_req_r  <= 1'b0;
            fetch_stop_r <= 1'b0;
            fetch_addr_r <= RESET_ADDR;
            pc_r         <= RESET_ADDR;
            count_r      <= '0;
            rd_r         <= '0;
            wr_r         <= '0;
        end else begin
            fetch_stop_r <= 1'b0;
            if (branch) begin
                count_r      <= '0;
                rd_r         <= '0;
                wr_r         <= '0;
                pc_r         <= branch_target_s;
                fetch_addr_r <= branch_target_s;
                case (state_r)
                    // Drop the request for a cycle; WAIT re-issues it at the new address.
                    // If memory accepted the old request this same cycle, end that stream.
                    FETCH: begin
                        fetch_req_r  <= 1'b0;
                        fetch_stop_r <= fetch_started;
                        state_r      <= WAIT;
                    end
                    STREAM: begin
                        fetch_req_r  <= 1'b0;
                        fetch_stop_r <= 1'b1;
                        state_r      <= WAIT;
                    end
                    WAIT: begin
                        fetch_req_r <= 1'b1;
                        state_r     <= FETCH;
                    end
                    default: begin
                        fetch_req_r <= 1'b0;
                        state_r     <= FETCH;
                    end
                endcase
            end else begin
                count_r <= next_count_s;
                if (push_s) begin
                    wr_r <= wr_r + PTR_W'(1'b1);
                end
                if (pop_s) begin
                    rd_r <= rd_r + PTR_W'(len_s);
                    pc_r <= pc_r + ADDR_W'({len_s, 1'b0});
                end
                case (state_r)
                    FETCH: begin
                        if (fetch_started) begin
                            fetch_req_r <= 1'b0;
                            state_r     <= STREAM;
                        end else begin
                            fetch_req_r <= 1'b1;
                        end
                    end
                    STREAM: begin
                        fetch_req_r <= 1'b0;
                        if (next_count_s == CNT_W'(DEPTH_HW)) begin
                            fetch_stop_r <= 1'b1;
                            state_r      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (count_r <= CNT_W'(DEPTH_HW - 2)) begin
                            fetch_req_r  <= 1'b1;
                            fetch_addr_r <= resume_addr_s;
                            state_r      <= FETCH;
                        end else begin
                            fetch_req_r <= 1'b0;
                        end
                    end
                    default: begin
                        fetch_req_r <= 1'b0;
                        state_r     <= FETCH;
                    end
                endcase
            end
        end
    end

    assign fetch_req   = fetch_req_r;
    assign fetch_stop  = fetch_stop_r;
    assign fetch_addr  = fetch_addr_r;
    assign pc          = pc_r;
    assign instr       = {hw_hi_s, hw_lo_s};
    assign instr_len   = len_s;
    assign instr_valid = valid_s;

endmodule

// File: tb/tb_tinyqv_fetch_buffer.sv
// tb_tinyqv_fetch_buffer
// Directed bench for tinyqv_fetch_buffer (DEPTH_HW = 4, ADDR_W = 24).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expectations follow TINYQV_FETCH_RVC_EN when it is defined.
module tb_tinyqv_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [23:0] fetch_addr;
    logic        fetch_started;
    logic [15:0] data_in;
    logic        data_valid;
    logic        fetch_stop;
    logic [31:0] instr;
    logic [23:0] pc;
    logic [1:0]  instr_len;
    logic        instr_valid;
    logic        instr_complete;
    logic        branch;
    logic [23:0] branch_addr;

    int tests_run;
    int tests_failed;

`ifdef TINYQV_FETCH_RVC_EN
    localparam logic [23:0] EXP_BR_PC   = 24'h000122;
    localparam logic [1:0]  EXP_LEN4501 = 2'b01;
    localparam logic        EXP_V4501   = 1'b1;
`else
    localparam logic [23:0] EXP_BR_PC   = 24'h000120;
    localparam logic [1:0]  EXP_LEN4501 = 2'b10;
    localparam logic        EXP_V4501   = 1'b0;
`endif

    tinyqv_fetch_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_started  (fetch_started),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .fetch_stop     (fetch_stop),
        .instr          (instr),
        .pc             (pc),
        .instr_len      (instr_len),
        .instr_valid    (instr_valid),
        .instr_complete (instr_complete),
        .branch         (branch),
        .branch_addr    (branch_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_hw(input logic [15:0] d);
        data_in    = d;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic pop_instr();
        instr_complete = 1'b1;
        @(negedge clk);
        instr_complete = 1'b0;
    endtask

    task automatic start_stream();
        fetch_started = 1'b1;
        @(negedge clk);
        fetch_started = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_req: got %b want 0", fetch_req); end
        tests_run++; if (fetch_stop !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_stop: got %b want 0", fetch_stop); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        tests_run++; if (pc !== 24'h000000) begin tests_failed++; $display("FAIL reset_pc: got %h want 000000", pc); end
        tests_run++; if (fetch_addr !== 24'h000000) begin tests_failed++; $display("FAIL reset_fetch_addr: got %h want 000000", fetch_addr); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (fetch_req !== 1'b1) begin tests_failed++; $display("FAIL release_fetch_req: got %b want 1", fetch_req); end
    endtask

    task automatic test_stream_fill();
        start_stream();
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL started_fetch_req: got %b want 0", fetch_req); end
        push_hw(16'h0013);
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL one_hw_32b_valid: got %b want 0", instr_valid); end
        repeat (3) @(negedge clk);
        push_hw(16'h0000);
        tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL two_hw_valid: got %b want 1", instr_valid); end
        tests_run++; if (instr !== 32'h00000013) begin tests_failed++; $display("FAIL first_instr: got %h want 00000013", instr); end
        tests_run++; if (pc !== 24'h000000) begin tests_failed++; $display("FAIL first_pc: got %h want 000000", pc); end
        tests_run++; if (instr_len !== 2'b10) begin tests_failed++; $display("FAIL first_len: got %b want 10", instr_len); end
        repeat (3) @(negedge clk);
        push_hw(16'h4501);
        tests_run++; if (fetch_stop !== 1'b0) begin tests_failed++; $display("FAIL early_stop: got %b want 0", fetch_stop); end
        repeat (3) @(negedge clk);
        push_hw(16'h0001);
        tests_run++; if (fetch_stop !== 1'b1) begin tests_failed++; $display("FAIL full_stop_pulse: got %b want 1", fetch_stop); end
        @(negedge clk);
        tests_run++; if (fetch_stop !== 1'b0) begin tests_failed++; $display("FAIL stop_one_cycle: got %b want 0", fetch_stop); end
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL full_no_req: got %b want 0", fetch_req); end
        @(negedge clk);
    endtask

    task automatic test_pop();
        pop_instr();
        tests_run++; if (pc !== 24'h000004) begin tests_failed++; $display("FAIL pop32_pc: got %h want 000004", pc); end
        tests_run++; if (instr !== 32'h00014501) begin tests_failed++; $display("FAIL pop32_instr: got %h want 00014501", instr); end
        tests_run++; if (instr_len !== EXP_LEN4501) begin tests_failed++; $display("FAIL len_4501: got %b want %b", instr_len, EXP_LEN4501); end
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL wait_no_req: got %b want 0", fetch_req); end
        @(negedge clk);
        tests_run++; if (fetch_req !== 1'b1) begin tests_failed++; $display("FAIL refetch_req: got %b want 1", fetch_req); end
        tests_run++; if (fetch_addr !== 24'h000008) begin tests_failed++; $display("FAIL refetch_addr: got %h want 000008", fetch_addr); end
        pop_instr();
`ifdef TINYQV_FETCH_RVC_EN
        tests_run++; if (pc !== 24'h000006) begin tests_failed++; $display("FAIL pop16_pc: got %h want 000006", pc); end
        tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL last16_valid: got %b want 1", instr_valid); end
        tests_run++; if (instr[15:0] !== 16'h0001) begin tests_failed++; $display("FAIL last16_instr: got %h want 0001", instr[15:0]); end
        pop_instr();
`endif
        tests_run++; if (pc !== 24'h000008) begin tests_failed++; $display("FAIL drained_pc: got %h want 000008", pc); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL drained_valid: got %b want 0", instr_valid); end
    endtask

    task automatic test_ring_wrap();
`ifdef TINYQV_FETCH_RVC_EN
        start_stream();
        push_hw(16'h0001); repeat (3) @(negedge clk);
        push_hw(16'h0001); repeat (3) @(negedge clk);
        push_hw(16'h0001); repeat (3) @(negedge clk);
        push_hw(16'h0013); repeat (3) @(negedge clk);
        pop_instr();
        pop_instr();
        pop_instr();
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_half_valid: got %b want 0", instr_valid); end
        tests_run++; if (fetch_addr !== 24'h000010) begin tests_failed++; $display("FAIL wrap_fetch_addr: got %h want 000010", fetch_addr); end
        start_stream();
        push_hw(16'h00AB);
        tests_run++; if (instr !== 32'h00AB0013) begin tests_failed++; $display("FAIL wrap_instr: got %h want 00ab0013", instr); end
        tests_run++; if (pc !== 24'h00000E) begin tests_failed++; $display("FAIL wrap_pc: got %h want 00000e", pc); end
`else
        start_stream();
        push_hw(16'hBEEF); repeat (3) @(negedge clk);
        push_hw(16'hCAFE);
        tests_run++; if (instr !== 32'hCAFEBEEF) begin tests_failed++; $display("FAIL wrap_instr: got %h want cafebeef", instr); end
        tests_run++; if (pc !== 24'h000008) begin tests_failed++; $display("FAIL wrap_pc: got %h want 000008", pc); end
`endif
        tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_valid: got %b want 1", instr_valid); end
        tests_run++; if (instr_len !== 2'b10) begin tests_failed++; $display("FAIL wrap_len: got %b want 10", instr_len); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_branch();
        data_in        = 16'h7777;
        data_valid     = 1'b1;
        instr_complete = 1'b1;
        branch         = 1'b1;
        branch_addr    = 24'h000123;
        @(negedge clk);
        data_valid     = 1'b0;
        instr_complete = 1'b0;
        branch         = 1'b0;
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL branch_flush: got %b want 0", instr_valid); end
        tests_run++; if (pc !== EXP_BR_PC) begin tests_failed++; $display("FAIL branch_pc: got %h want %h", pc, EXP_BR_PC); end
        tests_run++; if (fetch_stop !== 1'b1) begin tests_failed++; $display("FAIL branch_stop: got %b want 1", fetch_stop); end
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL branch_no_req: got %b want 0", fetch_req); end
        @(negedge clk);
        tests_run++; if (fetch_stop !== 1'b0) begin tests_failed++; $display("FAIL branch_stop_end: got %b want 0", fetch_stop); end
        tests_run++; if (fetch_req !== 1'b1) begin tests_failed++; $display("FAIL branch_req: got %b want 1", fetch_req); end
        tests_run++; if (fetch_addr !== EXP_BR_PC) begin tests_failed++; $display("FAIL branch_fetch_addr: got %h want %h", fetch_addr, EXP_BR_PC); end
    endtask

    task automatic test_reset_mid_stream();
        start_stream();
        push_hw(16'h4501);
        tests_run++; if (instr_valid !== EXP_V4501) begin tests_failed++; $display("FAIL lone_4501_valid: got %b want %b", instr_valid, EXP_V4501); end
        repeat (3) @(negedge clk);
        push_hw(16'h0002);
        tests_run++; if (instr !== 32'h00024501) begin tests_failed++; $display("FAIL post_branch_instr: got %h want 00024501", instr); end
        repeat (3) @(negedge clk);
        push_hw(16'h0003);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid: got %b want 0", instr_valid); end
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_req: got %b want 0", fetch_req); end
        tests_run++; if (fetch_stop !== 1'b0) begin tests_failed++; $display("FAIL midrst_stop: got %b want 0", fetch_stop); end
        tests_run++; if (pc !== 24'h000000) begin tests_failed++; $display("FAIL midrst_pc: got %h want 000000", pc); end
        tests_run++; if (fetch_addr !== 24'h000000) begin tests_failed++; $display("FAIL midrst_addr: got %h want 000000", fetch_addr); end
        @(negedge clk);
        tests_run++; if (fetch_req !== 1'b1) begin tests_failed++; $display("FAIL midrst_refetch: got %b want 1", fetch_req); end
    endtask

    task automatic test_branch_in_fetch();
        branch      = 1'b1;
        branch_addr = 24'h000041;
        @(negedge clk);
        branch = 1'b0;
        tests_run++; if (fetch_req !== 1'b0) begin tests_failed++; $display("FAIL fbr_req_drop: got %b want 0", fetch_req); end
        tests_run++; if (pc !== 24'h000040) begin tests_failed++; $display("FAIL fbr_pc: got %h want 000040", pc); end
        @(negedge clk);
        tests_run++; if (fetch_req !== 1'b1) begin tests_failed++; $display("FAIL fbr_req_again: got %b want 1", fetch_req); end
        tests_run++; if (fetch_addr !== 24'h000040) begin tests_failed++; $display("FAIL fbr_addr: got %h want 000040", fetch_addr); end
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        fetch_started  = 1'b0;
        data_in        = 16'h0000;
        data_valid     = 1'b0;
        instr_complete = 1'b0;
        branch         = 1'b0;
        branch_addr    = 24'h000000;
        test_reset();
        test_stream_fill();
        test_pop();
        test_ring_wrap();
        test_branch();
        test_reset_mid_stream();
        test_branch_in_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
